// File: rtl/ctrl_ajuste_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_ajuste_pkg
// Description : Shared types and constants for the clock set-mode controller.
//               Holds the operating-mode enum, the timeout default and a helper
//               that tells whether a mode is one of the set modes.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_ajuste_pkg;

    // Operating modes; encoding 2'd3 is never entered and decays to ST_RUN
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_MIN = 2'd1,
        ST_SET_HOR = 2'd2
    } estado_t;

    // Seconds without a button edge before a set mode gives up
    localparam int TIMEOUT_S_DEFAULT = 30;

    // Width of the idle-seconds counter
    localparam int TMO_WIDTH = 5;

    // True for the two modes in which the user is adjusting the time
    function automatic logic em_ajuste(input estado_t s);
        return (s == ST_SET_MIN) || (s == ST_SET_HOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sincroniza_botao.sv
`default_nettype none
// ============================================================================
// Module      : sincroniza_botao
// Description : Brings an asynchronous push-button into the clock domain with
//               a multi-flop synchronizer and emits a registered one-cycle
//               pulse on each rising edge of the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module sincroniza_botao #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulso
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   nivel_q;
    logic                   nivel_d;
    logic                   pulso_q;
    logic                   pulso_d;

    // Synchronizer shift: the raw button enters at bit 0
    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_comb begin
                sync_d = i_btn;
            end
        end else begin : g_chain
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
            end
        end
    endgenerate

    // Edge detect: pulse only when the synchronized level is new
    always_comb begin
        nivel_d = sync_q[SYNC_STAGES-1];
        pulso_d = sync_q[SYNC_STAGES-1] & ~nivel_q;
    end

    // Synchronizer, previous-level and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            nivel_q <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            nivel_q <= nivel_d;
            pulso_q <= pulso_d;
        end
    end

    assign o_pulso = pulso_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_ajuste.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_ajuste
// Description : Set-mode controller for a digital clock. Two buttons cycle
//               RUN -> SET_MIN -> SET_HOR -> RUN and request minute/hour
//               increments; requests are held until an enable1hz cycle
//               consumes them. Set modes freeze seconds, blink the digit
//               being adjusted and time out back to RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_ajuste
    import ctrl_ajuste_pkg::*;
#(
    parameter int TIMEOUT_S   = TIMEOUT_S_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       ctrl_ajuste_clock,
    input  logic       ctrl_ajuste_reset,
    input  logic       ctrl_ajuste_enable1hz,
    input  logic       ctrl_ajuste_btn_modo,
    input  logic       ctrl_ajuste_btn_inc,
    input  logic       ctrl_ajuste_incremento_segundo,
    output logic       ctrl_ajuste_incremento_minuto,
    output logic       ctrl_ajuste_incremento_hora,
    output logic       ctrl_ajuste_inibe_carry_hora,
    output logic       ctrl_ajuste_congela_segundos,
    output logic       ctrl_ajuste_exibe_m,
    output logic       ctrl_ajuste_exibe_h,
    output logic [1:0] ctrl_ajuste_modo
);

    localparam logic [TMO_WIDTH-1:0] TMO_LIMITE = TMO_WIDTH'(TIMEOUT_S - 1);

    estado_t              state_q;
    estado_t              state_d;
    logic                 pend_min_q;
    logic                 pend_min_d;
    logic                 pend_hora_q;
    logic                 pend_hora_d;
    logic [TMO_WIDTH-1:0] tmo_q;
    logic [TMO_WIDTH-1:0] tmo_d;
    logic                 blink_q;
    logic                 blink_d;
    logic                 inc_min_q;
    logic                 inc_min_d;
    logic                 inc_hora_q;
    logic                 inc_hora_d;

    logic                 modo_edge;
    logic                 inc_edge;
    logic                 em_set;
    logic                 expira;

    sincroniza_botao #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_modo (
        .clk     (ctrl_ajuste_clock),
        .rst     (ctrl_ajuste_reset),
        .i_btn   (ctrl_ajuste_btn_modo),
        .o_pulso (modo_edge)
    );

    sincroniza_botao #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_inc (
        .clk     (ctrl_ajuste_clock),
        .rst     (ctrl_ajuste_reset),
        .i_btn   (ctrl_ajuste_btn_inc),
        .o_pulso (inc_edge)
    );

    // Next-state logic for mode, pending requests, idle counter and blink
    always_comb begin
        state_d     = state_q;
        pend_min_d  = pend_min_q;
        pend_hora_d = pend_hora_q;
        tmo_d       = tmo_q;
        blink_d     = blink_q;

        em_set = em_ajuste(state_q);
        expira = em_set && ctrl_ajuste_enable1hz && (tmo_q == TMO_LIMITE)
                 && !modo_edge && !inc_edge;

        case (state_q)
            ST_RUN: begin
                if (modo_edge) state_d = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (modo_edge)   state_d = ST_SET_HOR;
                else if (expira) state_d = ST_RUN;
            end
            ST_SET_HOR: begin
                if (modo_edge)   state_d = ST_RUN;
                else if (expira) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A tick consumes whatever was pending; a new edge on the same
        // cycle re-arms the flag because it is applied afterwards.
        if (ctrl_ajuste_enable1hz) begin
            pend_min_d  = 1'b0;
            pend_hora_d = 1'b0;
        end
        if (inc_edge && !modo_edge) begin
            if (state_q == ST_SET_MIN) pend_min_d  = 1'b1;
            if (state_q == ST_SET_HOR) pend_hora_d = 1'b1;
        end

        if ((state_d != state_q) || modo_edge || inc_edge || !em_set) begin
            tmo_d = '0;
        end else if (ctrl_ajuste_enable1hz) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (state_d != state_q) begin
            blink_d = 1'b1;
        end else if (em_set && ctrl_ajuste_enable1hz) begin
            blink_d = ~blink_q;
        end

        // Request outputs track the flags so they are high on the very
        // tick that consumes them.
        inc_min_d  = pend_min_d | ((state_q == ST_RUN) & ctrl_ajuste_incremento_segundo);
        inc_hora_d = pend_hora_d;
    end

    // State and request registers
    always_ff @(posedge ctrl_ajuste_clock or posedge ctrl_ajuste_reset) begin
        if (ctrl_ajuste_reset) begin
            state_q     <= ST_RUN;
            pend_min_q  <= 1'b0;
            pend_hora_q <= 1'b0;
            tmo_q       <= '0;
            blink_q     <= 1'b1;
            inc_min_q   <= 1'b0;
            inc_hora_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_min_q  <= pend_min_d;
            pend_hora_q <= pend_hora_d;
            tmo_q       <= tmo_d;
            blink_q     <= blink_d;
            inc_min_q   <= inc_min_d;
            inc_hora_q  <= inc_hora_d;
        end
    end

    assign ctrl_ajuste_incremento_minuto = inc_min_q;
    assign ctrl_ajuste_incremento_hora   = inc_hora_q;
    assign ctrl_ajuste_inibe_carry_hora  = (state_q == ST_SET_MIN);
    assign ctrl_ajuste_congela_segundos  = em_ajuste(state_q);
    assign ctrl_ajuste_exibe_m           = (state_q == ST_SET_MIN) ? blink_q : 1'b1;
    assign ctrl_ajuste_exibe_h           = (state_q == ST_SET_HOR) ? blink_q : 1'b1;
    assign ctrl_ajuste_modo              = state_q;

endmodule
`default_nettype wire
